// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD-card host.
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } spi_state_t;

   // MOSI value for dummy bytes (card init clock train, response polling)
   localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

   // Half SCK periods in clk_sys cycles at 25 MHz: ~390 kHz init, 12.5 MHz fast
   localparam int unsigned SPI_H_SLOW_DEF = 32;
   localparam int unsigned SPI_H_FAST_DEF = 1;

endpackage

// File: rtl/sd_spi_master_if.sv
// CPU-side request/response bus of the SD SPI host.
interface sd_spi_master_if;

   logic       start;
   logic       start_burst;
   logic [7:0] burst_len;
   logic [7:0] tx_data;
   logic       slow;
   logic       cs_en;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;

   // Disk logic issuing byte requests
   modport master (
      output start, start_burst, burst_len, tx_data, slow, cs_en,
      input  busy, done, rx_data
   );

   // SPI host serving the requests
   modport slave (
      input  start, start_burst, burst_len, tx_data, slow, cs_en,
      output busy, done, rx_data
   );

endinterface

// File: rtl/sd_spi_halfclk.sv
// Loadable half-SCK-period down-counter; tick marks the last cycle of a half period.
module sd_spi_halfclk #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         run_q, run_d;

   // Reload on request, otherwise count down and stop after expiring
   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (load) begin
         cnt_d = load_val;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - W'(1);
         end
      end
   end

   // Counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign tick = run_q && (cnt_q == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 SD-card host: single bytes or 0xFF bursts, MSB first, slow/fast SCK.
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int unsigned H_SLOW = SPI_H_SLOW_DEF,
   parameter int unsigned H_FAST = SPI_H_FAST_DEF
) (
   input  logic           clk_sys,
   input  logic           reset_n,
   sd_spi_master_if.slave bus,
   output logic           sd_sck,
   output logic           sd_cs,
   output logic           sd_sdi,
   input  logic           sd_sdo
);

   // Counter is sized for the slow rate; H_FAST is expected to be <= H_SLOW
   localparam int unsigned   HW      = $clog2(H_SLOW + 1);
   localparam logic [HW-1:0] SLOW_M1 = HW'(H_SLOW - 1);
   localparam logic [HW-1:0] FAST_M1 = HW'(H_FAST - 1);

   spi_state_t    state_q, state_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    rem_q, rem_d;
   logic          slow_q, slow_d;
   logic          sck_q, sck_d;
   logic          sdi_q, sdi_d;
   logic          cs_q, cs_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    rx_q, rx_d;

   logic          hc_load;
   logic [HW-1:0] hc_val;
   logic          hc_tick;

   sd_spi_halfclk #(
      .W(HW)
   ) u_halfclk (
      .clk      (clk_sys),
      .rst_n    (reset_n),
      .load     (hc_load),
      .load_val (hc_val),
      .tick     (hc_tick)
   );

   // Transfer sequencing: next state, shift register and registered pin values
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      slow_d  = slow_q;
      sck_d   = sck_q;
      sdi_d   = sdi_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = done_q;
      rx_d    = rx_q;
      hc_load = 1'b0;
      hc_val  = slow_q ? SLOW_M1 : FAST_M1;

      unique case (state_q)
         IDLE: begin
            cs_d = ~bus.cs_en;
            if (bus.start) begin
               shreg_d = bus.tx_data;
               rem_d   = 8'd1;
               idx_d   = '0;
               slow_d  = bus.slow;
               sdi_d   = bus.tx_data[7];
               busy_d  = 1'b1;
               hc_load = 1'b1;
               hc_val  = bus.slow ? SLOW_M1 : FAST_M1;
               state_d = LOW;
            end else if (bus.start_burst) begin
               busy_d = 1'b1;
               if (bus.burst_len != 8'd0) begin
                  shreg_d = SPI_IDLE_BYTE;
                  rem_d   = bus.burst_len;
                  idx_d   = '0;
                  slow_d  = bus.slow;
                  sdi_d   = 1'b1;
                  hc_load = 1'b1;
                  hc_val  = bus.slow ? SLOW_M1 : FAST_M1;
                  state_d = LOW;
               end else begin
                  state_d = DONE;
               end
            end
         end

         LOW: begin
            if (hc_tick) begin
               sck_d   = 1'b1;
               shreg_d = {shreg_q[6:0], sd_sdo};
               hc_load = 1'b1;
               state_d = HIGH;
            end
         end

         HIGH: begin
            if (hc_tick) begin
               sck_d = 1'b0;
               if (idx_q != 3'd7) begin
                  sdi_d   = shreg_q[7];
                  idx_d   = idx_q + 3'd1;
                  hc_load = 1'b1;
                  state_d = LOW;
               end else begin
                  rx_d  = shreg_q;
                  rem_d = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
                  if (rem_q <= 8'd1) begin
                     // done is raised on this edge so it lands 16*H*N+1 after the request
                     done_d  = 1'b1;
                     sdi_d   = 1'b1;
                     state_d = DONE;
                  end else begin
                     shreg_d = SPI_IDLE_BYTE;
                     sdi_d   = 1'b1;
                     idx_d   = '0;
                     hc_load = 1'b1;
                     state_d = LOW;
                  end
               end
            end
         end

         DONE: begin
            // Zero-length bursts arrive here with done still low: pulse first, then leave
            if (!done_q) begin
               done_d = 1'b1;
            end else begin
               done_d  = 1'b0;
               busy_d  = 1'b0;
               sdi_d   = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         slow_q  <= 1'b0;
         sck_q   <= 1'b0;
         sdi_q   <= 1'b1;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         slow_q  <= slow_d;
         sck_q   <= sck_d;
         sdi_q   <= sdi_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rx_q    <= rx_d;
      end
   end

   assign sd_sck      = sck_q;
   assign sd_cs       = cs_q;
   assign sd_sdi      = sdi_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master with a mode-0 card responder.
module tb_sd_spi_master;

   localparam int unsigned HS  = 32;
   localparam int unsigned HF  = 1;
   localparam time         CLK = 40;

   logic clk_sys = 1'b0;
   logic reset_n;
   logic sd_sck, sd_cs, sd_sdi, sd_sdo;

   sd_spi_master_if bus ();

   sd_spi_master #(
      .H_SLOW (HS),
      .H_FAST (HF)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus),
      .sd_sck  (sd_sck),
      .sd_cs   (sd_cs),
      .sd_sdi  (sd_sdi),
      .sd_sdo  (sd_sdo)
   );

   always #(CLK / 2) clk_sys = ~clk_sys;

   int tests_run    = 0;
   int tests_failed = 0;

   // Responder: presents resp_byte MSB first, advancing on each SCK fall
   logic [7:0] resp_byte = 8'hFF;
   int         resp_base = 0;
   int         fall_cnt  = 0;
   logic [2:0] resp_idx;
   assign resp_idx = 3'(fall_cnt - resp_base);
   assign sd_sdo   = resp_byte[3'd7 - resp_idx];

   always @(negedge sd_sck) fall_cnt++;

   // SCK rise monitor: pulse count, MOSI capture, rise times
   int         rise_cnt  = 0;
   int         mosi_zero = 0;
   logic [7:0] mosi_sr   = '0;
   time        rise_t[$];

   always @(posedge sd_sck) begin
      rise_cnt++;
      mosi_sr = {mosi_sr[6:0], sd_sdi};
      if (sd_sdi !== 1'b1) mosi_zero++;
      rise_t.push_back($time);
   end

   int done_cnt = 0;
   always @(posedge clk_sys) if (bus.done === 1'b1) done_cnt++;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic set_resp(input logic [7:0] b);
      resp_byte = b;
      resp_base = fall_cnt;
   endtask

   // Issue one request and follow it to done; n counts edges since the request cycle
   task automatic do_request(
      input  logic       st,
      input  logic       sb,
      input  logic [7:0] len,
      input  logic [7:0] tx,
      input  int         max_cyc,
      input  int         inject_at,
      output int         done_at,
      output int         n_done,
      output logic       busy1,
      output logic       busy_after,
      output int         cs_chg,
      output time        t_e0
   );
      logic cs0;
      bus.start       = st;
      bus.start_burst = sb;
      bus.burst_len   = len;
      bus.tx_data     = tx;
      @(posedge clk_sys);
      t_e0 = $time;
      #1;
      bus.start       = 1'b0;
      bus.start_burst = 1'b0;
      done_at    = -1;
      n_done     = 0;
      busy1      = bus.busy;
      busy_after = 1'bx;
      cs_chg     = 0;
      cs0        = sd_cs;
      for (int n = 1; n <= max_cyc; n++) begin
         if (bus.done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = n;
         end
         if (done_at >= 0 && n == done_at + 1) busy_after = bus.busy;
         if ((done_at < 0 || n <= done_at) && sd_cs !== cs0) cs_chg++;
         if (done_at >= 0 && n >= done_at + 4) break;
         if (n == inject_at) begin
            bus.start       = 1'b1;
            bus.tx_data     = 8'h12;
            bus.start_burst = 1'b1;
            bus.burst_len   = 8'd3;
            bus.cs_en       = ~bus.cs_en;
            bus.slow        = ~bus.slow;
         end else if (n == inject_at + 1) begin
            bus.start       = 1'b0;
            bus.start_burst = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset_n         = 1'b0;
      bus.start       = 1'b0;
      bus.start_burst = 1'b0;
      bus.burst_len   = '0;
      bus.tx_data     = '0;
      bus.slow        = 1'b0;
      bus.cs_en       = 1'b0;
      repeat (3) step();
      tests_run++; if (sd_sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck got %b exp 0", sd_sck); end
      tests_run++; if (sd_sdi !== 1'b1) begin tests_failed++; $display("FAIL reset_sdi got %b exp 1", sd_sdi); end
      tests_run++; if (sd_cs !== 1'b1) begin tests_failed++; $display("FAIL reset_cs got %b exp 1", sd_cs); end
      tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", bus.done); end
      tests_run++; if (bus.rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx got %h exp 00", bus.rx_data); end
      reset_n = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_fast_byte();
      int done_at, n_done, cs_chg, r0, z0;
      logic busy1, busy_after;
      time t_e0;
      bus.cs_en = 1'b1;
      bus.slow  = 1'b0;
      repeat (2) step();
      tests_run++; if (sd_cs !== 1'b0) begin tests_failed++; $display("FAIL fast_cs_sel got %b exp 0", sd_cs); end
      set_resp(8'h3C);
      r0 = rise_cnt;
      z0 = mosi_zero;
      do_request(1'b1, 1'b0, 8'd0, 8'hA5, 40, -1, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL fast_busy_rise got %b exp 1", busy1); end
      tests_run++; if (done_at != 17) begin tests_failed++; $display("FAIL fast_done_cycle got %0d exp 17", done_at); end
      tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL fast_done_count got %0d exp 1", n_done); end
      tests_run++; if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL fast_busy_fall got %b exp 0", busy_after); end
      tests_run++; if (rise_cnt - r0 != 8) begin tests_failed++; $display("FAIL fast_sck_pulses got %0d exp 8", rise_cnt - r0); end
      tests_run++; if (mosi_sr !== 8'hA5) begin tests_failed++; $display("FAIL fast_mosi got %h exp a5", mosi_sr); end
      tests_run++; if (mosi_zero - z0 != 4) begin tests_failed++; $display("FAIL fast_mosi_zeros got %0d exp 4", mosi_zero - z0); end
      tests_run++; if (bus.rx_data !== 8'h3C) begin tests_failed++; $display("FAIL fast_rx got %h exp 3c", bus.rx_data); end
      tests_run++; if (cs_chg != 0) begin tests_failed++; $display("FAIL fast_cs_stable got %0d exp 0", cs_chg); end
      tests_run++;
      if (rise_t.size() <= r0 || rise_t[r0] - t_e0 != HF * CLK) begin
         tests_failed++;
         $display("FAIL fast_first_rise got %0t exp %0t", (rise_t.size() > r0) ? rise_t[r0] - t_e0 : 0, HF * CLK);
      end
   endtask

   task automatic test_slow_burst();
      int done_at, n_done, cs_chg, r0, z0, bad_gap;
      logic busy1, busy_after;
      time t_e0;
      bus.cs_en = 1'b0;
      bus.slow  = 1'b1;
      repeat (2) step();
      tests_run++; if (sd_cs !== 1'b1) begin tests_failed++; $display("FAIL burst_cs_desel got %b exp 1", sd_cs); end
      set_resp(8'hFF);
      r0 = rise_cnt;
      z0 = mosi_zero;
      do_request(1'b0, 1'b1, 8'd10, 8'h00, 5200, -1, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (done_at != 5121) begin tests_failed++; $display("FAIL burst_done_cycle got %0d exp 5121", done_at); end
      tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL burst_done_count got %0d exp 1", n_done); end
      tests_run++; if (rise_cnt - r0 != 80) begin tests_failed++; $display("FAIL burst_sck_pulses got %0d exp 80", rise_cnt - r0); end
      tests_run++; if (mosi_zero - z0 != 0) begin tests_failed++; $display("FAIL burst_mosi_zeros got %0d exp 0", mosi_zero - z0); end
      tests_run++; if (cs_chg != 0 || sd_cs !== 1'b1) begin tests_failed++; $display("FAIL burst_cs_high got %0d/%b exp 0/1", cs_chg, sd_cs); end
      tests_run++; if (bus.rx_data !== 8'hFF) begin tests_failed++; $display("FAIL burst_rx got %h exp ff", bus.rx_data); end
      bad_gap = 0;
      for (int i = r0 + 1; i < r0 + 80; i++) begin
         if (i >= rise_t.size() || rise_t[i] - rise_t[i - 1] != 2 * HS * CLK) bad_gap++;
      end
      tests_run++; if (bad_gap != 0) begin tests_failed++; $display("FAIL burst_sck_gaps got %0d exp 0", bad_gap); end
      tests_run++;
      if (rise_t.size() <= r0 || rise_t[r0] - t_e0 != HS * CLK) begin
         tests_failed++;
         $display("FAIL burst_first_rise got %0t exp %0t", (rise_t.size() > r0) ? rise_t[r0] - t_e0 : 0, HS * CLK);
      end
   endtask

   task automatic test_ignored();
      int done_at, n_done, cs_chg, r0;
      logic busy1, busy_after;
      time t_e0;
      bus.cs_en = 1'b1;
      bus.slow  = 1'b0;
      repeat (2) step();
      set_resp(8'h81);
      r0 = rise_cnt;
      // At n=3 inject start(0x12)+start_burst and flip cs_en/slow mid-byte
      do_request(1'b1, 1'b0, 8'd0, 8'hC3, 60, 3, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (done_at != 17) begin tests_failed++; $display("FAIL ign_done_cycle got %0d exp 17", done_at); end
      tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL ign_done_count got %0d exp 1", n_done); end
      tests_run++; if (rise_cnt - r0 != 8) begin tests_failed++; $display("FAIL ign_sck_pulses got %0d exp 8", rise_cnt - r0); end
      tests_run++; if (mosi_sr !== 8'hC3) begin tests_failed++; $display("FAIL ign_mosi got %h exp c3", mosi_sr); end
      tests_run++; if (bus.rx_data !== 8'h81) begin tests_failed++; $display("FAIL ign_rx got %h exp 81", bus.rx_data); end
      tests_run++; if (cs_chg != 0) begin tests_failed++; $display("FAIL ign_cs_midxfer got %0d exp 0", cs_chg); end
      tests_run++; if (sd_cs !== 1'b1) begin tests_failed++; $display("FAIL ign_cs_idle got %b exp 1", sd_cs); end
      tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL ign_idle_busy got %b exp 0", bus.busy); end
      bus.slow = 1'b0;
   endtask

   task automatic test_edges();
      int done_at, n_done, cs_chg, r0;
      logic busy1, busy_after;
      time t_e0;
      bus.cs_en = 1'b1;
      bus.slow  = 1'b0;
      repeat (2) step();
      r0 = rise_cnt;
      do_request(1'b0, 1'b1, 8'd0, 8'h00, 20, -1, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (done_at != 2) begin tests_failed++; $display("FAIL zero_done_cycle got %0d exp 2", done_at); end
      tests_run++; if (n_done != 1) begin tests_failed++; $display("FAIL zero_done_count got %0d exp 1", n_done); end
      tests_run++; if (rise_cnt - r0 != 0) begin tests_failed++; $display("FAIL zero_sck_pulses got %0d exp 0", rise_cnt - r0); end
      tests_run++; if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_fall got %b exp 0", busy_after); end
      set_resp(8'h96);
      r0 = rise_cnt;
      do_request(1'b1, 1'b1, 8'd5, 8'h5A, 100, -1, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (done_at != 17) begin tests_failed++; $display("FAIL both_done_cycle got %0d exp 17", done_at); end
      tests_run++; if (rise_cnt - r0 != 8) begin tests_failed++; $display("FAIL both_sck_pulses got %0d exp 8", rise_cnt - r0); end
      tests_run++; if (mosi_sr !== 8'h5A) begin tests_failed++; $display("FAIL both_mosi got %h exp 5a", mosi_sr); end
      tests_run++; if (bus.rx_data !== 8'h96) begin tests_failed++; $display("FAIL both_rx got %h exp 96", bus.rx_data); end
   endtask

   task automatic test_reset_mid();
      int done_at, n_done, cs_chg, r0, d0, waited;
      logic busy1, busy_after;
      time t_e0;
      bus.cs_en = 1'b1;
      bus.slow  = 1'b0;
      repeat (2) step();
      set_resp(8'hFF);
      r0 = rise_cnt;
      bus.start   = 1'b1;
      bus.tx_data = 8'h00;
      step();
      bus.start = 1'b0;
      waited = 0;
      while (rise_cnt - r0 < 4 && waited < 40) begin
         step();
         waited++;
      end
      tests_run++; if (rise_cnt - r0 != 4) begin tests_failed++; $display("FAIL rmid_reach_rise4 got %0d exp 4", rise_cnt - r0); end
      #5;
      d0 = done_cnt;
      reset_n = 1'b0;
      #1;
      tests_run++; if (sd_sck !== 1'b0) begin tests_failed++; $display("FAIL rmid_sck got %b exp 0", sd_sck); end
      tests_run++; if (sd_sdi !== 1'b1) begin tests_failed++; $display("FAIL rmid_sdi got %b exp 1", sd_sdi); end
      tests_run++; if (sd_cs !== 1'b1) begin tests_failed++; $display("FAIL rmid_cs got %b exp 1", sd_cs); end
      tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
      repeat (3) step();
      reset_n = 1'b1;
      repeat (4) step();
      tests_run++; if (done_cnt != d0) begin tests_failed++; $display("FAIL rmid_no_done got %0d exp %0d", done_cnt, d0); end
      set_resp(8'h17);
      r0 = rise_cnt;
      do_request(1'b1, 1'b0, 8'd0, 8'h69, 40, -1, done_at, n_done, busy1, busy_after, cs_chg, t_e0);
      tests_run++; if (done_at != 17) begin tests_failed++; $display("FAIL rmid_next_done got %0d exp 17", done_at); end
      tests_run++; if (mosi_sr !== 8'h69) begin tests_failed++; $display("FAIL rmid_next_mosi got %h exp 69", mosi_sr); end
      tests_run++; if (bus.rx_data !== 8'h17) begin tests_failed++; $display("FAIL rmid_next_rx got %h exp 17", bus.rx_data); end
   endtask

   initial begin
      test_reset();
      test_fast_byte();
      test_slow_burst();
      test_ignored();
      test_edges();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
